// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the async FIFO write port and the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wr_data;
  logic                     grant_vld;
  logic [ID_W-1:0]          grant_id;
  logic                     abort;

  // Requesters plus FIFO status side.
  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_vld, grant_id, abort
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_vld, grant_id, abort
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; grant registered (first write 1 cycle after request),
// writes pass through combinationally, fifo_full stalls the grant and a long stall aborts it.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 16,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BCW-1:0] BURST_END = BCW'(MAX_BURST - 1);
  localparam logic [TCW-1:0] STALL_END = TCW'(TIMEOUT - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic [BCW-1:0]   burst_q, burst_d;
  logic [TCW-1:0]   stall_q, stall_d;
  logic             abort_q, abort_d;

  logic               g_valid, g_last;
  logic [WIDTH-1:0]   g_data;
  logic [NUM_REQ-1:0] g_mask;
  logic               pick_found;
  logic [ID_W-1:0]    pick;
  logic [NUM_REQ-1:0] ready;
  logic               wr_en;
  logic [WIDTH-1:0]   wr_data;

  // Fields of the currently granted requester.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    g_mask  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == ID_W'(i)) begin
        g_mask[i] = 1'b1;
        g_valid   = bus.req_valid[i];
        g_last    = bus.req_last[i];
        g_data    = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // First valid requester strictly after the previous grant, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pick_found && (i == (int'(last_q) + k) % NUM_REQ) && bus.req_valid[i]) begin
          pick_found = 1'b1;
          pick       = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    burst_d = burst_q;
    stall_d = stall_q;
    abort_d = 1'b0;
    ready   = '0;
    wr_en   = 1'b0;
    wr_data = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = XFER;
          gid_d   = pick;
          last_d  = pick;
          burst_d = '0;
          stall_d = '0;
        end
      end
      XFER: begin
        ready = g_mask & {NUM_REQ{~bus.fifo_full}};
        if (g_valid && !bus.fifo_full) begin
          wr_en   = 1'b1;
          wr_data = g_data;
          burst_d = burst_q + 1'b1;
          stall_d = '0;
          if (g_last || burst_q == BURST_END) state_d = IDLE;
        end else if (!g_valid) begin
          state_d = IDLE;
        end else if (stall_q == STALL_END) begin
          // Requester keeps its word; abort is seen in the IDLE cycle that follows.
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      gid_q   <= '0;
      burst_q <= '0;
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_wr_data = wr_data;
  assign bus.grant_vld    = (state_q == XFER);
  assign bus.grant_id     = gid_q;
  assign bus.abort        = abort_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed cycle table, hand-written corner sequences, random traffic vs a model.
module tb_fifo_wr_arbiter;
  localparam int WIDTH     = 8;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  fifo_wr_arbiter #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the port, words sent and consecutive full cycles in this grant.
  bit m_busy;
  int m_owner, m_gid, m_prev, m_sent, m_stall;
  bit m_abort;

  int          seq [NUM_REQ];
  logic [3:0]  acc;
  logic [7:0]  wr_log [$];
  int          abort_seen;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic        f;
    logic [31:0] d;
    logic        gv;
    logic [1:0]  gid;
    logic [3:0]  rdy;
    logic        wr;
    logic [7:0]  wd;
    logic        ab;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_gid = 0; m_prev = NUM_REQ - 1;
    m_sent = 0; m_stall = 0; m_abort = 0;
  endtask

  task automatic apply_check(input logic [3:0] v, input logic [3:0] l, input logic f,
                             input logic [31:0] d);
    logic [3:0] e_rdy;
    logic       e_wr;
    logic [7:0] e_wd;
    bit         nxt_abort;
    bit         found;
    int         idx;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.fifo_full = f;
    bus.req_data  = d;
    #1;
    e_rdy = '0; e_wr = 1'b0; e_wd = '0;
    if (m_busy) begin
      if (!f) e_rdy[m_owner] = 1'b1;
      e_wr = v[m_owner] & ~f;
      if (e_wr) e_wd = d[m_owner*8 +: 8];
    end
    chk("grant_vld",    32'(bus.grant_vld),    32'(m_busy));
    chk("grant_id",     32'(bus.grant_id),     32'(m_gid));
    chk("req_ready",    32'(bus.req_ready),    32'(e_rdy));
    chk("fifo_wr_en",   32'(bus.fifo_wr_en),   32'(e_wr));
    chk("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(e_wd));
    chk("abort",        32'(bus.abort),        32'(m_abort));
    acc = '0;
    if (e_wr) acc[m_owner] = 1'b1;
    nxt_abort = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (m_prev + k) % NUM_REQ;
        if (!found && v[idx]) begin
          found = 1; m_owner = idx; m_gid = idx; m_prev = idx;
          m_busy = 1; m_sent = 0; m_stall = 0;
        end
      end
    end else if (e_wr) begin
      m_sent++;
      m_stall = 0;
      if (l[m_owner] || m_sent == MAX_BURST) m_busy = 0;
    end else if (!v[m_owner]) begin
      m_busy = 0;
    end else begin
      m_stall++;
      if (m_stall == TIMEOUT) begin
        m_busy = 0;
        nxt_abort = 1;
      end
    end
    m_abort = nxt_abort;
  endtask

  // One clock of traffic; requester i presents byte {i, seq[i]}.
  task automatic run_cycle(input logic [3:0] v, input logic [3:0] l, input logic f);
    logic [31:0] d;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) d[i*8 +: 8] = 8'(i*64 + seq[i] % 64);
    apply_check(v, l, f, d);
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) seq[i]++;
    if (bus.fifo_wr_en) wr_log.push_back(bus.fifo_wr_data);
    if (bus.abort) abort_seen++;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '1; bus.req_last = '0; bus.fifo_full = 1'b0; bus.req_data = '1;
    #1;
    chk("rst_grant_vld", 32'(bus.grant_vld),    32'd0);
    chk("rst_grant_id",  32'(bus.grant_id),     32'd0);
    chk("rst_req_ready", 32'(bus.req_ready),    32'd0);
    chk("rst_wr_en",     32'(bus.fifo_wr_en),   32'd0);
    chk("rst_wr_data",   32'(bus.fifo_wr_data), 32'd0);
    chk("rst_abort",     32'(bus.abort),        32'd0);
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;
    wr_log.delete();
    abort_seen = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] vld_r, last_r, l_now;
    int full_left, free_left;
    logic f;

    //            v        l        f     d             gv  gid    rdy      wr  wd     ab
    tbl[0]  = '{4'b0100, 4'b0000, 1'b0, 32'h00A10000, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, 1'b0, 32'h00A10000, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA1, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0000, 1'b0, 32'h00A20000, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA2, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0100, 1'b0, 32'h00A30000, 1'b1, 2'd2, 4'b0100, 1'b1, 8'hA3, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 32'h00000000, 1'b0, 2'd2, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{4'b1010, 4'b0000, 1'b0, 32'hC100B100, 1'b0, 2'd2, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{4'b1010, 4'b0000, 1'b0, 32'hC100B100, 1'b1, 2'd3, 4'b1000, 1'b1, 8'hC1, 1'b0};
    tbl[7]  = '{4'b0010, 4'b0000, 1'b0, 32'hC100B100, 1'b1, 2'd3, 4'b1000, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{4'b0010, 4'b0000, 1'b0, 32'hC100B100, 1'b0, 2'd3, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0000, 1'b1, 32'hC100B100, 1'b1, 2'd1, 4'b0000, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{4'b0010, 4'b0010, 1'b0, 32'hC100B100, 1'b1, 2'd1, 4'b0010, 1'b1, 8'hB1, 1'b0};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 32'h00000000, 1'b0, 2'd1, 4'b0000, 1'b0, 8'h00, 1'b0};

    bus.req_valid = '0; bus.req_last = '0; bus.fifo_full = 1'b0; bus.req_data = '0;

    // Single requester packet, then valid drop after one word and a 1-cycle full stall.
    reset_dut();
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      bus.req_valid = tbl[r].v; bus.req_last = tbl[r].l;
      bus.fifo_full = tbl[r].f; bus.req_data = tbl[r].d;
      #1;
      chk($sformatf("tbl%0d.grant_vld", r), 32'(bus.grant_vld),    32'(tbl[r].gv));
      chk($sformatf("tbl%0d.grant_id", r),  32'(bus.grant_id),     32'(tbl[r].gid));
      chk($sformatf("tbl%0d.req_ready", r), 32'(bus.req_ready),    32'(tbl[r].rdy));
      chk($sformatf("tbl%0d.wr_en", r),     32'(bus.fifo_wr_en),   32'(tbl[r].wr));
      chk($sformatf("tbl%0d.wr_data", r),   32'(bus.fifo_wr_data), 32'(tbl[r].wd));
      chk($sformatf("tbl%0d.abort", r),     32'(bus.abort),        32'(tbl[r].ab));
    end

    // All requesters valid: grants 0,1,2,3,0, four words each, one idle cycle between.
    reset_dut();
    for (int c = 0; c < 25; c++) begin
      run_cycle(4'b1111, 4'b0000, 1'b0);
      chk("rr_wr_en", 32'(bus.fifo_wr_en), 32'((c % 5) != 0));
      if (c % 5 != 0) chk("rr_grant_id", 32'(bus.grant_id), 32'((c / 5) % 4));
    end

    // Full for 5 cycles mid-burst: nothing accepted, burst resumes without loss or repeat.
    reset_dut();
    run_cycle(4'b0001, 4'b0000, 1'b0);
    run_cycle(4'b0001, 4'b0000, 1'b0);
    run_cycle(4'b0001, 4'b0000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      run_cycle(4'b0001, 4'b0000, 1'b1);
      chk("stall_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    end
    run_cycle(4'b0001, 4'b0000, 1'b0);
    run_cycle(4'b0001, 4'b0001, 1'b0);
    run_cycle(4'b0000, 4'b0000, 1'b0);
    chk("stall_words", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("stall_order", 32'(wr_log[i]), 32'(i));

    // Full for 16 cycles: one abort, grant moves to requester 1, stalled word written later.
    reset_dut();
    run_cycle(4'b0011, 4'b0010, 1'b0);
    for (int c = 0; c < 16; c++) run_cycle(4'b0011, 4'b0010, 1'b1);
    run_cycle(4'b0011, 4'b0010, 1'b0);
    chk("to_abort_pulse", 32'(bus.abort), 32'd1);
    run_cycle(4'b0011, 4'b0010, 1'b0);
    chk("to_next_grant", 32'(bus.grant_id), 32'd1);
    run_cycle(4'b0001, 4'b0001, 1'b0);
    run_cycle(4'b0001, 4'b0001, 1'b0);
    run_cycle(4'b0000, 4'b0000, 1'b0);
    chk("to_abort_count", 32'(abort_seen), 32'd1);
    chk("to_words", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("to_word0", 32'(wr_log[0]), 32'h40);
      chk("to_word1", 32'(wr_log[1]), 32'h00);
    end

    // Reset during the 2nd word of a burst.
    reset_dut();
    run_cycle(4'b0100, 4'b0000, 1'b0);
    run_cycle(4'b0100, 4'b0000, 1'b0);
    run_cycle(4'b0100, 4'b0000, 1'b0);
    chk("mid_rst_pre_wr", 32'(bus.fifo_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en",   32'(bus.fifo_wr_en),   32'd0);
    chk("mid_rst_vld",     32'(bus.grant_vld),    32'd0);
    chk("mid_rst_ready",   32'(bus.req_ready),    32'd0);
    chk("mid_rst_wr_data", 32'(bus.fifo_wr_data), 32'd0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("in_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    end
    bus.req_valid = '0;
    rst = 1'b0;
    model_reset();
    run_cycle(4'b1111, 4'b0000, 1'b0);
    run_cycle(4'b1111, 4'b0000, 1'b0);
    chk("post_rst_grant", 32'(bus.grant_id), 32'd0);
    chk("post_rst_vld",   32'(bus.grant_vld), 32'd1);

    // Random traffic against the model.
    reset_dut();
    vld_r = '0; last_r = '0; full_left = 0; free_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (full_left == 0 && free_left == 0) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 5)       full_left = $urandom_range(15, 20);
        else if (r < 40) full_left = $urandom_range(1, 4);
        else             free_left = $urandom_range(1, 6);
      end
      if (full_left > 0) begin f = 1'b1; full_left--; end
      else               begin f = 1'b0; free_left--; end
      l_now = last_r;
      run_cycle(vld_r, l_now, f);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          vld_r[i]  = ($urandom_range(0, 9) < 7);
          last_r[i] = ($urandom_range(0, 3) == 0);
        end else if (vld_r[i]) begin
          if ($urandom_range(0, 19) == 0) vld_r[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 3) begin
          vld_r[i]  = 1'b1;
          last_r[i] = ($urandom_range(0, 3) == 0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
